// File: rtl/fir_sched_pkg.sv
// Shared types for the FIR job scheduler: FSM state encoding, job descriptor
// layout and the default field widths.
package fir_sched_pkg;

  localparam int DEF_DEPTH    = 4;
  localparam int DEF_WSP_W    = 6;
  localparam int DEF_PROBKI_W = 14;
  localparam int DEF_RAZY_W   = 15;
  localparam int DEF_ACK_TMO  = 8;
  localparam int DEF_WDOG_W   = 20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_FIN   = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [DEF_WSP_W-1:0]    ile_wsp;
    logic [DEF_PROBKI_W-1:0] ile_probek;
    logic [DEF_RAZY_W-1:0]   ile_razy;
  } fir_job_t;

  // A job with any zero count is meaningless to the FIR and is rejected.
  function automatic logic job_has_zero(input fir_job_t job);
    return (job.ile_wsp == {DEF_WSP_W{1'b0}}) ||
           (job.ile_probek == {DEF_PROBKI_W{1'b0}}) ||
           (job.ile_razy == {DEF_RAZY_W{1'b0}});
  endfunction

endpackage

// File: rtl/fir_job_fifo.sv
// Descriptor FIFO for the FIR scheduler; flush clears it and wins over a
// simultaneous push or pop.
module fir_job_fifo
  import fir_sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fir_job_t                 din,
  input  logic                     pop,
  input  logic                     flush,
  output fir_job_t                 dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  fir_job_t      mem_r [DEPTH];
  logic          full_s;
  logic          empty_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign push_ok_s = push && !full_s && !flush;
  assign pop_ok_s  = pop && !empty_s && !flush;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Descriptor storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/fir_job_sched.sv
// Queues FIR job descriptors and runs them one at a time on the FIR engine.
// Optional run watchdog enabled by defining FIR_SCHED_WDOG_EN.
module fir_job_sched
  import fir_sched_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int WSP_W    = DEF_WSP_W,
  parameter int PROBKI_W = DEF_PROBKI_W,
  parameter int RAZY_W   = DEF_RAZY_W,
  parameter int ACK_TMO  = DEF_ACK_TMO
`ifdef FIR_SCHED_WDOG_EN
  ,
  parameter int WDOG_W   = DEF_WDOG_W
`endif
) (
  input  logic                     a_clk,
  input  logic                     a_rst_n,
  input  logic                     j_valid,
  output logic                     j_ready,
  input  logic [WSP_W-1:0]         j_ile_wsp,
  input  logic [PROBKI_W-1:0]      j_ile_probek,
  input  logic [RAZY_W-1:0]        j_ile_razy,
  input  logic                     flush,
  output logic [WSP_W-1:0]         f_ile_wsp,
  output logic [PROBKI_W-1:0]      f_ile_probek,
  output logic [RAZY_W-1:0]        f_ile_razy,
  output logic                     f_start,
  input  logic                     f_pracuje,
  input  logic                     f_done,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     busy,
  output logic                     job_done,
  output logic                     job_err,
  output logic                     err_sticky
`ifdef FIR_SCHED_WDOG_EN
  ,
  output logic                     wdog_hit
`endif
);

  localparam int TMO_W = $clog2(ACK_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

  sched_state_e            state_r;
  sched_state_e            state_s;
  fir_job_t                push_job_s;
  fir_job_t                head_s;
  fir_job_t                job_r;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic                    pop_s;
  logic                    load_s;
  logic                    err_s;
  logic [TMO_W-1:0]        tmo_cnt_r;
  logic [TMO_W-1:0]        tmo_cnt_s;
  logic [WSP_W-1:0]        f_ile_wsp_r;
  logic [PROBKI_W-1:0]     f_ile_probek_r;
  logic [RAZY_W-1:0]       f_ile_razy_r;
  logic                    f_start_r;
  logic                    busy_r;
  logic                    job_done_r;
  logic                    job_err_r;
  logic                    err_sticky_r;
`ifdef FIR_SCHED_WDOG_EN
  logic [WDOG_W-1:0]       wdog_cnt_r;
  logic [WDOG_W-1:0]       wdog_cnt_s;
  logic                    wdog_s;
  logic                    wdog_hit_r;
`endif

  assign push_job_s = '{ile_wsp: j_ile_wsp, ile_probek: j_ile_probek, ile_razy: j_ile_razy};

  fir_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (a_clk),
    .rst_n (a_rst_n),
    .push  (j_valid),
    .din   (push_job_s),
    .pop   (pop_s),
    .flush (flush),
    .dout  (head_s),
    .count (q_count),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign j_ready = !fifo_full_s;

  // Next-state and single-cycle event decode.
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    load_s    = 1'b0;
    err_s     = 1'b0;
    tmo_cnt_s = tmo_cnt_r;
`ifdef FIR_SCHED_WDOG_EN
    wdog_cnt_s = wdog_cnt_r;
    wdog_s     = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        // A head discarded by flush this cycle must not be started.
        if (!fifo_empty_s && !flush) begin
          pop_s   = 1'b1;
          state_s = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (job_has_zero(job_r)) begin
          err_s   = 1'b1;
          state_s = S_IDLE;
        end else begin
          load_s    = 1'b1;
          tmo_cnt_s = {TMO_W{1'b0}};
          state_s   = S_START;
        end
      end
      S_START: begin
        if (f_pracuje) begin
          if (f_done) begin
            state_s = S_FIN;
          end else begin
            state_s = S_RUN;
`ifdef FIR_SCHED_WDOG_EN
            wdog_cnt_s = {WDOG_W{1'b0}};
`endif
          end
        end else if (tmo_cnt_r == TMO_LAST) begin
          err_s   = 1'b1;
          state_s = S_IDLE;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
          state_s   = S_START;
        end
      end
      S_RUN: begin
        if (f_done) begin
          state_s = S_FIN;
`ifdef FIR_SCHED_WDOG_EN
        end else if (wdog_cnt_r == {WDOG_W{1'b1}}) begin
          err_s   = 1'b1;
          wdog_s  = 1'b1;
          state_s = S_IDLE;
        end else begin
          wdog_cnt_s = wdog_cnt_r + WDOG_W'(1);
          state_s    = S_RUN;
`else
        end else begin
          state_s = S_RUN;
`endif
        end
      end
      S_FIN: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_r   <= S_IDLE;
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      state_r   <= state_s;
      tmo_cnt_r <= tmo_cnt_s;
    end
  end

`ifdef FIR_SCHED_WDOG_EN
  // Run watchdog counter and its pulse.
  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
      wdog_hit_r <= 1'b0;
    end else begin
      wdog_cnt_r <= wdog_cnt_s;
      wdog_hit_r <= wdog_s;
    end
  end

  assign wdog_hit = wdog_hit_r;
`endif

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      job_r          <= '0;
      f_ile_wsp_r    <= {WSP_W{1'b0}};
      f_ile_probek_r <= {PROBKI_W{1'b0}};
      f_ile_razy_r   <= {RAZY_W{1'b0}};
      f_start_r      <= 1'b0;
      busy_r         <= 1'b0;
      job_done_r     <= 1'b0;
      job_err_r      <= 1'b0;
      err_sticky_r   <= 1'b0;
    end else begin
      if (pop_s) begin
        job_r <= head_s;
      end
      if (load_s) begin
        f_ile_wsp_r    <= job_r.ile_wsp;
        f_ile_probek_r <= job_r.ile_probek;
        f_ile_razy_r   <= job_r.ile_razy;
      end
      f_start_r    <= (state_s == S_START);
      busy_r       <= (state_s != S_IDLE);
      job_done_r   <= (state_s == S_FIN);
      job_err_r    <= err_s;
      err_sticky_r <= err_sticky_r | err_s;
    end
  end

  assign f_ile_wsp    = f_ile_wsp_r;
  assign f_ile_probek = f_ile_probek_r;
  assign f_ile_razy   = f_ile_razy_r;
  assign f_start      = f_start_r;
  assign busy         = busy_r;
  assign job_done     = job_done_r;
  assign job_err      = job_err_r;
  assign err_sticky   = err_sticky_r;

endmodule

// File: tb/tb_fir_job_sched.sv
// Directed bench for fir_job_sched; the bench itself plays the FIR engine.
// Define FIR_SCHED_WDOG_EN to also exercise the run watchdog.
module tb_fir_job_sched;

  logic          a_clk;
  logic          a_rst_n;
  logic          j_valid;
  logic          j_ready;
  logic [5:0]    j_ile_wsp;
  logic [13:0]   j_ile_probek;
  logic [14:0]   j_ile_razy;
  logic          flush;
  logic [5:0]    f_ile_wsp;
  logic [13:0]   f_ile_probek;
  logic [14:0]   f_ile_razy;
  logic          f_start;
  logic          f_pracuje;
  logic          f_done;
  logic [2:0]    q_count;
  logic          busy;
  logic          job_done;
  logic          job_err;
  logic          err_sticky;
`ifdef FIR_SCHED_WDOG_EN
  logic          wdog_hit;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_start = 0;
  logic f_start_q = 1'b0;

  fir_job_sched #(
    .DEPTH(4), .WSP_W(6), .PROBKI_W(14), .RAZY_W(15), .ACK_TMO(8)
`ifdef FIR_SCHED_WDOG_EN
    , .WDOG_W(4)
`endif
  ) dut (
    .a_clk(a_clk), .a_rst_n(a_rst_n),
    .j_valid(j_valid), .j_ready(j_ready),
    .j_ile_wsp(j_ile_wsp), .j_ile_probek(j_ile_probek), .j_ile_razy(j_ile_razy),
    .flush(flush),
    .f_ile_wsp(f_ile_wsp), .f_ile_probek(f_ile_probek), .f_ile_razy(f_ile_razy),
    .f_start(f_start), .f_pracuje(f_pracuje), .f_done(f_done),
    .q_count(q_count), .busy(busy), .job_done(job_done), .job_err(job_err),
    .err_sticky(err_sticky)
`ifdef FIR_SCHED_WDOG_EN
    , .wdog_hit(wdog_hit)
`endif
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  // Event counters observed on the active edge.
  always @(posedge a_clk) begin
    if (job_done) n_done <= n_done + 1;
    if (job_err) n_err <= n_err + 1;
    if (f_start && !f_start_q) n_start <= n_start + 1;
    f_start_q <= f_start;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  task automatic push_one(input int w, input int p, input int r);
    j_valid = 1'b1;
    j_ile_wsp = 6'(w);
    j_ile_probek = 14'(p);
    j_ile_razy = 15'(r);
    tick();
    j_valid = 1'b0;
  endtask

  // Wait (bounded) for f_start, ack it one cycle later, end in RUN.
  task automatic start_and_ack(input string tag);
    int k;
    k = 0;
    while (!f_start && k < 12) begin
      tick();
      k++;
    end
    chk({tag, "_start"}, 32'(f_start), 32'd1);
    tick();
    f_pracuje = 1'b1;
    chk({tag, "_start_held"}, 32'(f_start), 32'd1);
    tick();
    chk({tag, "_start_drop"}, 32'(f_start), 32'd0);
  endtask

  task automatic finish_job(input string tag);
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
    f_pracuje = 1'b0;
    chk({tag, "_job_done"}, 32'(job_done), 32'd1);
  endtask

  initial begin
    int k;
    int s0;
    int d0;
    a_rst_n = 1'b0;
    j_valid = 1'b0;
    j_ile_wsp = 6'd0;
    j_ile_probek = 14'd0;
    j_ile_razy = 15'd0;
    flush = 1'b0;
    f_pracuje = 1'b0;
    f_done = 1'b0;
    #3;
    chk("rst_j_ready", 32'(j_ready), 32'd1);
    chk("rst_f_start", 32'(f_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    chk("rst_f_ile_probek", 32'(f_ile_probek), 32'd0);
    #19 a_rst_n = 1'b1;
    tick();

    // Single job: f_start three cycles after the push cycle, held two cycles.
    j_valid = 1'b1; j_ile_wsp = 6'd16; j_ile_probek = 14'd1000; j_ile_razy = 15'd1;
    tick();
    j_valid = 1'b0;
    chk("t1_q_count", 32'(q_count), 32'd1);
    chk("t1_idle_no_start", 32'(f_start), 32'd0);
    tick();
    chk("t1_load_busy", 32'(busy), 32'd1);
    chk("t1_load_no_start", 32'(f_start), 32'd0);
    tick();
    chk("t1_start", 32'(f_start), 32'd1);
    chk("t1_wsp", 32'(f_ile_wsp), 32'd16);
    chk("t1_probek", 32'(f_ile_probek), 32'd1000);
    chk("t1_razy", 32'(f_ile_razy), 32'd1);
    tick();
    f_pracuje = 1'b1;
    chk("t1_start_held", 32'(f_start), 32'd1);
    tick();
    chk("t1_run_start_low", 32'(f_start), 32'd0);
    repeat (48) tick();
    chk("t1_run_busy", 32'(busy), 32'd1);
    finish_job("t1");
    chk("t1_fin_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_after_busy", 32'(busy), 32'd0);
    chk("t1_after_done", 32'(job_done), 32'd0);
    chk("t1_done_count", 32'(n_done), 32'd1);
    chk("t1_wsp_hold", 32'(f_ile_wsp), 32'd16);

    // Queue fills to DEPTH while a job is stalled in RUN; jobs drain in order.
    push_one(7, 7, 7);
    start_and_ack("t2a");
    for (int i = 1; i <= 4; i++) push_one(i, 100 + i, i);
    chk("t2_q_full", 32'(q_count), 32'd4);
    chk("t2_not_ready", 32'(j_ready), 32'd0);
    j_valid = 1'b1; j_ile_wsp = 6'd5; j_ile_probek = 14'd105; j_ile_razy = 15'd5;
    tick();
    chk("t2_fifth_held", 32'(q_count), 32'd4);
    finish_job("t2a");
    k = 0;
    while (!j_ready && k < 10) begin
      tick();
      k++;
    end
    chk("t2_ready_again", 32'(j_ready), 32'd1);
    tick();
    j_valid = 1'b0;
    chk("t2_fifth_in", 32'(q_count), 32'd4);
    for (int i = 1; i <= 5; i++) begin
      start_and_ack($sformatf("t2_job%0d", i));
      chk($sformatf("t2_wsp%0d", i), 32'(f_ile_wsp), 32'(i));
      chk($sformatf("t2_probek%0d", i), 32'(f_ile_probek), 32'(100 + i));
      finish_job($sformatf("t2_job%0d", i));
    end
    tick();
    chk("t2_done_count", 32'(n_done), 32'd7);
    chk("t2_no_err", 32'(err_sticky), 32'd0);

    // Zero repeat count between two valid jobs.
    s0 = n_start;
    push_one(3, 3, 3);
    push_one(4, 4, 0);
    push_one(5, 5, 5);
    start_and_ack("t3a");
    chk("t3a_wsp", 32'(f_ile_wsp), 32'd3);
    finish_job("t3a");
    start_and_ack("t3b");
    chk("t3b_wsp", 32'(f_ile_wsp), 32'd5);
    chk("t3_err_count", 32'(n_err), 32'd1);
    chk("t3_err_sticky", 32'(err_sticky), 32'd1);
    finish_job("t3b");
    chk("t3_starts", 32'(n_start - s0), 32'd2);

    // FIR never acks: f_start held ACK_TMO cycles, then the next job runs.
    tick();
    push_one(9, 9, 9);
    push_one(10, 10, 10);
    k = 0;
    while (!f_start && k < 12) begin
      tick();
      k++;
    end
    k = 0;
    while (f_start && k < 20) begin
      tick();
      k++;
    end
    chk("t4_start_width", 32'(k), 32'd8);
    chk("t4_job_err", 32'(job_err), 32'd1);
    start_and_ack("t4b");
    chk("t4b_wsp", 32'(f_ile_wsp), 32'd10);
    finish_job("t4b");
    chk("t4_err_count", 32'(n_err), 32'd2);

    // Flush three queued jobs while one runs; a simultaneous push is dropped.
    tick();
    push_one(11, 11, 11);
    start_and_ack("t5");
    push_one(12, 12, 12);
    push_one(13, 13, 13);
    push_one(14, 14, 14);
    chk("t5_q_count", 32'(q_count), 32'd3);
    flush = 1'b1;
    j_valid = 1'b1; j_ile_wsp = 6'd15; j_ile_probek = 14'd15; j_ile_razy = 15'd15;
    tick();
    flush = 1'b0;
    j_valid = 1'b0;
    chk("t5_flushed", 32'(q_count), 32'd0);
    s0 = n_start;
    finish_job("t5");
    repeat (8) tick();
    chk("t5_no_start", 32'(n_start - s0), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

    // Reset in the middle of a running job.
    push_one(2, 2, 2);
    start_and_ack("t6");
    push_one(3, 3, 3);
    a_rst_n = 1'b0;
    #2;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_q_count", 32'(q_count), 32'd0);
    chk("t6_err_sticky", 32'(err_sticky), 32'd0);
    chk("t6_wsp", 32'(f_ile_wsp), 32'd0);
    f_pracuje = 1'b0;
    #4 a_rst_n = 1'b1;
    tick();
    tick();
    chk("t6_stays_idle", 32'(busy), 32'd0);

`ifdef FIR_SCHED_WDOG_EN
    // Watchdog fires after 16 RUN cycles; a late f_done is ignored.
    push_one(1, 1, 1);
    start_and_ack("t7");
    k = 0;
    while (!wdog_hit && k < 40) begin
      tick();
      k++;
    end
    chk("t7_wdog_cycles", 32'(k), 32'd16);
    chk("t7_job_err", 32'(job_err), 32'd1);
    d0 = n_done;
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
    f_pracuje = 1'b0;
    repeat (3) tick();
    chk("t7_no_done", 32'(n_done - d0), 32'd0);
`else
    d0 = n_done;
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
    repeat (3) tick();
    chk("t7_stray_done", 32'(n_done - d0), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
